// File: rtl/spi_master_cs.sv
// SPI master with chip-select framing: serialises bytes onto MOSI, captures MISO,
// keeps CS low across the bytes of a frame and enforces an inactive gap between frames.
module spi_master_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          w_SPI_Clk,
  input  logic          i_Rst_L,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_SPI_Clk,
  input  logic          i_SPI_MISO,
  output logic          o_SPI_MOSI,
  output logic          o_SPI_CS_n
);

  localparam logic          CPOL      = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic          CPHA      = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int            HW        = $clog2(CLKS_PER_HALF_BIT);
  localparam int            GW        = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_INACTIVE_CLKS - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BYTES_PER_CS);
  localparam logic [2:0]    FIRST_BIT = CPHA ? 3'd7 : 3'd6;

  typedef enum logic [1:0] {IDLE, XFER, CS_HOLD, CS_GAP} state_t;

  // A zero count still means one byte; oversize counts saturate at the frame limit.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cnt);
    if (cnt == '0)          return CW'(1);
    else if (cnt > MAX_CNT) return MAX_CNT;
    else                    return cnt;
  endfunction

  state_t        r_State;
  state_t        w_Next_State;
  logic [HW-1:0] r_Half_Cnt;
  logic [4:0]    r_Edge_Cnt;
  logic [GW-1:0] r_Gap_Cnt;
  logic [2:0]    r_TX_Bit;
  logic [7:0]    r_TX_Byte;
  logic [7:0]    r_RX_Shift;
  logic [7:0]    r_RX_Byte;
  logic [CW-1:0] r_Frame_Cnt;
  logic [CW-1:0] r_Byte_Idx;
  logic [CW-1:0] r_RX_Count;
  logic          r_RX_DV;
  logic          r_SPI_Clk;
  logic          r_MOSI;

  logic          w_Accept;
  logic          w_Edge_Fire;
  logic          w_Leading;
  logic          w_Sample;
  logic          w_Drive;
  logic          w_Xfer_Done;
  logic          w_Gap_Done;
  logic [CW:0]   w_Next_Idx;
  logic          w_More;

  assign w_Accept    = i_TX_DV & o_TX_Ready;
  assign w_Edge_Fire = (r_State == XFER) && (r_Edge_Cnt != 5'd0) && (r_Half_Cnt == HALF_LAST);
  // Edge number is 17 - r_Edge_Cnt, so odd (leading) edges see an even count.
  assign w_Leading   = ~r_Edge_Cnt[0];
  assign w_Sample    = CPHA ? ~w_Leading : w_Leading;
  assign w_Drive     = CPHA ? w_Leading : (~w_Leading & (r_Edge_Cnt != 5'd1));
  assign w_Xfer_Done = (r_State == XFER) && (r_Edge_Cnt == 5'd0);
  assign w_Gap_Done  = (r_Gap_Cnt == GAP_LAST);
  assign w_Next_Idx  = {1'b0, r_Byte_Idx} + (CW+1)'(1);
  assign w_More      = w_Next_Idx < {1'b0, r_Frame_Cnt};

  assign o_RX_Count  = r_RX_Count;
  assign o_RX_DV     = r_RX_DV;
  assign o_RX_Byte   = r_RX_Byte;
  assign o_SPI_Clk   = r_SPI_Clk;
  assign o_SPI_MOSI  = r_MOSI;

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= IDLE;
    else          r_State <= w_Next_State;
  end

  always_comb begin
    w_Next_State = r_State;
    o_TX_Ready   = 1'b0;
    o_SPI_CS_n   = 1'b1;
    case (r_State)
      IDLE: begin
        o_TX_Ready = 1'b1;
        if (w_Accept) w_Next_State = XFER;
      end
      XFER: begin
        o_SPI_CS_n = 1'b0;
        if (w_Xfer_Done) w_Next_State = w_More ? CS_HOLD : CS_GAP;
      end
      CS_HOLD: begin
        o_TX_Ready = 1'b1;
        o_SPI_CS_n = 1'b0;
        if (w_Accept) w_Next_State = XFER;
      end
      CS_GAP: begin
        if (w_Gap_Done) w_Next_State = IDLE;
      end
      default: w_Next_State = IDLE;
    endcase
  end

  // Byte load, edge engine, shift registers and frame bookkeeping
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Half_Cnt  <= '0;
      r_Edge_Cnt  <= '0;
      r_Gap_Cnt   <= '0;
      r_TX_Bit    <= '0;
      r_TX_Byte   <= '0;
      r_RX_Shift  <= '0;
      r_RX_Byte   <= '0;
      r_Frame_Cnt <= '0;
      r_Byte_Idx  <= '0;
      r_RX_Count  <= '0;
      r_RX_DV     <= 1'b0;
      r_SPI_Clk   <= CPOL;
      r_MOSI      <= 1'b0;
    end else begin
      r_RX_DV <= 1'b0;

      if (w_Accept) begin
        r_TX_Byte  <= i_TX_Byte;
        r_Half_Cnt <= '0;
        r_Edge_Cnt <= 5'd16;
        r_TX_Bit   <= FIRST_BIT;
        if (!CPHA) r_MOSI <= i_TX_Byte[7];
        if (r_State == IDLE) begin
          r_Frame_Cnt <= clamp_count(i_TX_Count);
          r_Byte_Idx  <= '0;
          r_RX_Count  <= '0;
        end
      end

      if ((r_State == XFER) && (r_Edge_Cnt != 5'd0)) begin
        r_Half_Cnt <= (r_Half_Cnt == HALF_LAST) ? '0 : r_Half_Cnt + HW'(1);
      end

      if (w_Edge_Fire) begin
        r_SPI_Clk  <= ~r_SPI_Clk;
        r_Edge_Cnt <= r_Edge_Cnt - 5'd1;
        if (w_Sample) r_RX_Shift <= {r_RX_Shift[6:0], i_SPI_MISO};
        if (w_Drive) begin
          r_MOSI   <= r_TX_Byte[r_TX_Bit];
          r_TX_Bit <= r_TX_Bit - 3'd1;
        end
      end

      if (w_Xfer_Done) begin
        r_RX_DV    <= 1'b1;
        r_RX_Byte  <= r_RX_Shift;
        r_RX_Count <= r_Byte_Idx;
        if (w_More) r_Byte_Idx <= r_Byte_Idx + CW'(1);
      end

      if (r_State == CS_GAP) r_Gap_Cnt <= w_Gap_Done ? '0 : r_Gap_Cnt + GW'(1);
      else                   r_Gap_Cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_master_cs.sv
// Bench for spi_master_cs: one instance per SPI mode, each with a protocol-level slave
// model (or MOSI loopback), driven by directed and random frames.
module tb_spi_master_cs;

  localparam int N   = 2;
  localparam int MAX = 2;
  localparam int GAP = 1;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_l = 1'b1;
  logic [CW-1:0] tx_count = '0;
  logic [7:0]    tx_byte = '0;
  logic [3:0]    tx_dv = '0;
  logic [3:0]    ready, rx_dv, sclk, mosi, cs_n;
  logic [3:0]    miso;
  logic [CW-1:0] rx_count [4];
  logic [7:0]    rx_byte [4];

  logic [3:0]    loopb = 4'b0001;
  logic [7:0]    sl_tx [4];
  logic [7:0]    sl_rx [4];
  logic [3:0]    prev_clk, prev_mosi, prev_cs;
  int            e [4];
  int            edges_tot [4];
  int            rises [4];
  int            mosi_viol [4];
  int            idle_viol [4];
  int            rxdv_cnt [4];
  int            cs_rises [4];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_cs #(
      .SPI_MODE(g), .CLKS_PER_HALF_BIT(N), .MAX_BYTES_PER_CS(MAX), .CS_INACTIVE_CLKS(GAP)
    ) u_dut (
      .w_SPI_Clk (clk),
      .i_Rst_L   (rst_l),
      .i_TX_Count(tx_count),
      .i_TX_Byte (tx_byte),
      .i_TX_DV   (tx_dv[g]),
      .o_TX_Ready(ready[g]),
      .o_RX_Count(rx_count[g]),
      .o_RX_DV   (rx_dv[g]),
      .o_RX_Byte (rx_byte[g]),
      .o_SPI_Clk (sclk[g]),
      .i_SPI_MISO(miso[g]),
      .o_SPI_MOSI(mosi[g]),
      .o_SPI_CS_n(cs_n[g])
    );
  end

  function automatic bit f_cpha(input int k);
    return (k % 2) == 1;
  endfunction

  function automatic bit f_cpol(input int k);
    return k >= 2;
  endfunction

  // Slave output bit after ev SPI edges: CPHA=0 shifts on trailing edges, CPHA=1 on leading.
  function automatic logic [2:0] miso_idx(input int k, input int ev);
    int m;
    m = ev % 16;
    if (f_cpha(k)) return (m == 0) ? 3'd7 : 3'(7 - (m - 1) / 2);
    else           return 3'(7 - m / 2);
  endfunction

  always_comb begin
    miso = '0;
    for (int k = 0; k < 4; k++)
      miso[k] = loopb[k] ? mosi[k] : sl_tx[k][miso_idx(k, e[k])];
  end

  always @(negedge clk) begin : mon
    int ne;
    bit chg, odd, smp, drv, ok;
    for (int k = 0; k < 4; k++) begin
      chg = (sclk[k] !== prev_clk[k]);
      ne  = (!cs_n[k] && chg) ? e[k] + 1 : e[k];
      odd = (ne % 2) == 1;
      smp = (odd != f_cpha(k));
      drv = f_cpha(k) ? odd : (!odd && (ne % 16) != 0);
      ok  = chg ? drv : (!f_cpha(k) && (e[k] % 16) == 0);
      e[k] <= cs_n[k] ? 0 : ne;
      if (!cs_n[k] && chg) begin
        edges_tot[k] <= edges_tot[k] + 1;
        if (sclk[k]) rises[k] <= rises[k] + 1;
        if (smp) sl_rx[k] <= {sl_rx[k][6:0], mosi[k]};
      end
      if (!cs_n[k] && (mosi[k] !== prev_mosi[k]) && !ok) mosi_viol[k] <= mosi_viol[k] + 1;
      if (cs_n[k] && (sclk[k] !== f_cpol(k))) idle_viol[k] <= idle_viol[k] + 1;
      if (rx_dv[k]) rxdv_cnt[k] <= rxdv_cnt[k] + 1;
      if (cs_n[k] && !prev_cs[k]) cs_rises[k] <= cs_rises[k] + 1;
    end
    prev_clk  <= sclk;
    prev_mosi <= mosi;
    prev_cs   <= cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge; returns at the falling edge of cycle 1 after the accept.
  task automatic send(input int k, input logic [7:0] b, input int c);
    int w;
    w = 0;
    while (!ready[k] && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", ready[k], 1);
    tx_byte  = b;
    tx_count = CW'(c);
    tx_dv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_dv[k] = 1'b0;
  endtask

  task automatic wait_rx(input int k, output int cyc, output int fe);
    cyc = 1;
    fe  = -1;
    while (!rx_dv[k] && cyc < 300) begin
      if (fe < 0 && sclk[k] !== f_cpol(k)) fe = cyc;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_frame(input int k, input int cnt, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] s0, input logic [7:0] s1, input int dly);
    int exp_len, cyc, fe, e0, r0, c0, v0, i0;
    logic [7:0] tb_b, sb, exp_rx;
    exp_len = (cnt == 0) ? 1 : ((cnt > MAX) ? MAX : cnt);
    e0 = edges_tot[k]; r0 = rises[k]; c0 = cs_rises[k]; v0 = mosi_viol[k]; i0 = idle_viol[k];
    for (int b = 0; b < exp_len; b++) begin
      tb_b = (b == 0) ? b0 : b1;
      sb   = (b == 0) ? s0 : s1;
      if (b > 0) repeat (dly) @(negedge clk);
      sl_tx[k] = sb;
      send(k, tb_b, (b == 0) ? cnt : 0);
      chk("ready_low_c1", ready[k], 0);
      chk("cs_low_c1", cs_n[k], 0);
      wait_rx(k, cyc, fe);
      chk("first_edge_cycle", fe, 1 + N);
      chk("rx_dv_cycle", cyc, 2 + 16 * N);
      exp_rx = loopb[k] ? tb_b : sb;
      chk("rx_byte", rx_byte[k], exp_rx);
      chk("rx_count", rx_count[k], b);
      chk("slave_rx", sl_rx[k], tb_b);
      chk("spi_edges", edges_tot[k] - e0, 16 * (b + 1));
      chk("spi_rises", rises[k] - r0, 8 * (b + 1));
      if (b < exp_len - 1) begin
        chk("cs_held", cs_n[k], 0);
        chk("hold_ready", ready[k], 1);
      end else begin
        chk("cs_end", cs_n[k], 1);
        chk("gap_ready", ready[k], 0);
      end
    end
    @(negedge clk);
    chk("rx_dv_one_cycle", rx_dv[k], 0);
    chk("ready_after_gap", ready[k], 1);
    chk("cs_rises", cs_rises[k] - c0, 1);
    chk("mosi_edge_rule", mosi_viol[k] - v0, 0);
    chk("idle_clk_cpol", idle_viol[k] - i0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fe, c0, d0, e0, k, cnt;
    for (int i = 0; i < 4; i++) sl_tx[i] = 8'h00;
    #1 rst_l = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", ready[0], 1);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_sclk_m0", sclk[0], 0);
    chk("rst_sclk_m3", sclk[3], 1);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_rx_dv", rx_dv[0], 0);
    chk("rst_rx_byte", rx_byte[0], 0);
    chk("rst_rx_count", rx_count[0], 0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    loopb = 4'b0001;
    run_frame(0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0);

    for (int m = 1; m < 4; m++) run_frame(m, 1, 8'hC3, 8'h00, 8'h3C, 8'h00, 0);

    run_frame(0, 2, 8'h12, 8'h34, 8'h00, 8'h00, 10);
    run_frame(0, 0, 8'h69, 8'h00, 8'h00, 8'h00, 0);
    run_frame(2, 3, 8'hB7, 8'h4E, 8'hD1, 8'h2C, 0);

    for (int it = 0; it < 8; it++) begin
      k   = $urandom_range(3, 0);
      cnt = $urandom_range(3, 0);
      loopb[k] = 1'($urandom_range(1, 0));
      run_frame(k, cnt, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(3, 0));
    end

    loopb[0] = 1'b1;
    c0 = cs_rises[0]; d0 = rxdv_cnt[0]; e0 = edges_tot[0];
    send(0, 8'h3E, 1);
    repeat (8) @(negedge clk);
    tx_dv[0] = 1'b1;
    @(negedge clk);
    tx_dv[0] = 1'b0;
    wait_rx(0, cyc, fe);
    chk("ignored_dv_rx_cycle", cyc + 9, 2 + 16 * N);
    chk("ignored_dv_rx_byte", rx_byte[0], 8'h3E);
    tx_dv[0] = 1'b1;
    @(negedge clk);
    tx_dv[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("ignored_dv_rxdv", rxdv_cnt[0] - d0, 1);
    chk("ignored_dv_edges", edges_tot[0] - e0, 16);
    chk("ignored_dv_cs", cs_rises[0] - c0, 1);
    chk("ignored_dv_idle", cs_n[0], 1);

    send(0, 8'h81, 1);
    repeat (14) @(negedge clk);
    chk("edge7_sclk", sclk[0], 1);
    d0 = rxdv_cnt[0];
    #2 rst_l = 1'b0;
    #1;
    chk("midrst_ready", ready[0], 1);
    chk("midrst_cs_n", cs_n[0], 1);
    chk("midrst_sclk", sclk[0], 0);
    chk("midrst_mosi", mosi[0], 0);
    chk("midrst_rx_dv", rx_dv[0], 0);
    chk("midrst_rx_byte", rx_byte[0], 0);
    chk("midrst_rx_count", rx_count[0], 0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_rxdv", rxdv_cnt[0] - d0, 0);
    run_frame(0, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
